// File: rtl/nec_ir_decoder_pkg.sv
// Shared NEC timing: tick windows, timeout, bit count, FSM state encoding and frame layout.
package nec_ir_decoder_pkg;

    localparam int          NEC_BITS       = 32;
    localparam logic [11:0] WIDTH_MAX      = 12'd4095;
    localparam logic [11:0] TIMEOUT_TICKS  = 12'd1100;

    localparam logic [11:0] LEAD_MARK_MIN  = 12'd800;
    localparam logic [11:0] LEAD_MARK_MAX  = 12'd1000;
    localparam logic [11:0] LEAD_SPACE_MIN = 12'd400;
    localparam logic [11:0] LEAD_SPACE_MAX = 12'd500;
    localparam logic [11:0] RPT_SPACE_MIN  = 12'd200;
    localparam logic [11:0] RPT_SPACE_MAX  = 12'd250;
    localparam logic [11:0] BIT_MARK_MIN   = 12'd40;
    localparam logic [11:0] BIT_MARK_MAX   = 12'd70;
    localparam logic [11:0] ZERO_SPACE_MIN = 12'd40;
    localparam logic [11:0] ZERO_SPACE_MAX = 12'd70;
    localparam logic [11:0] ONE_SPACE_MIN  = 12'd140;
    localparam logic [11:0] ONE_SPACE_MAX  = 12'd200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_RPT_MARK
    } nec_state_e;

    // Bits arrive LSB first, so after 32 right-shifts the first byte sits at [7:0].
    typedef struct packed {
        logic [7:0] cmd_n;
        logic [7:0] cmd;
        logic [7:0] addr_n;
        logic [7:0] addr;
    } nec_frame_t;

    function automatic logic in_win(input logic [11:0] w, input logic [11:0] lo,
                                    input logic [11:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/nec_ir_decoder_if.sv
// Receiver pin plus decoded command bus between the decoder and the channel controller.
interface nec_ir_decoder_if;
    logic       ir_in;
    logic [7:0] ir_cmd;
    logic [7:0] ir_addr;
    logic       ir_valid;
    logic       ir_repeat;
    logic       ir_err;

    modport master (input ir_in, output ir_cmd, ir_addr, ir_valid, ir_repeat, ir_err);
    modport slave  (output ir_in, input ir_cmd, ir_addr, ir_valid, ir_repeat, ir_err);
endinterface

// File: rtl/nec_ir_decoder_ir_pulse_timer.sv
// Synchronises the IR pin, finds mark/space edges and measures each level's width in ticks.
module ir_pulse_timer
    import nec_ir_decoder_pkg::*;
#(
    parameter int CLKS_PER_TICK = 500,
    parameter bit IR_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_i,
    output logic        mark_start_o,
    output logic        mark_end_o,
    output logic        space_end_o,
    output logic [11:0] width_o,
    output logic        timeout_o
);

    localparam int          PW       = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_TICK - 1);
    localparam logic        IDLE_RAW = IR_ACTIVE_LOW;

    logic [1:0]    sync_q, sync_d;
    logic          mark_q, mark_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [11:0]   cnt_q, cnt_d;
    logic [11:0]   width_q, width_d;
    logic          mstart_q, mstart_d;
    logic          mend_q, mend_d;
    logic          tmo_q, tmo_d;

    logic mark_now, edge_det, tick;

    always_comb begin
        // XOR with the idle level turns the raw pin into mark=1 for either polarity.
        mark_now = sync_q[1] ^ IDLE_RAW;
        edge_det = mark_now ^ mark_q;
        tick     = (pre_q == PRE_LAST);

        sync_d   = {sync_q[0], ir_i};
        mark_d   = mark_now;
        pre_d    = (edge_det || tick) ? '0 : pre_q + PW'(1);
        cnt_d    = cnt_q;
        if (edge_det)
            cnt_d = '0;
        else if (tick && (cnt_q != WIDTH_MAX))
            cnt_d = cnt_q + 12'd1;
        width_d  = edge_det ? cnt_q : width_q;
        mstart_d = edge_det & mark_now;
        mend_d   = edge_det & ~mark_now;
        // Fires once as the level crosses the limit; the saturating count never re-arms it.
        tmo_d    = !edge_det && tick && (cnt_q == TIMEOUT_TICKS - 12'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {2{IDLE_RAW}};
            mark_q   <= 1'b0;
            pre_q    <= '0;
            cnt_q    <= '0;
            width_q  <= '0;
            mstart_q <= 1'b0;
            mend_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            mark_q   <= mark_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            mstart_q <= mstart_d;
            mend_q   <= mend_d;
            tmo_q    <= tmo_d;
        end
    end

    assign mark_start_o = mstart_q;
    assign space_end_o  = mstart_q;
    assign mark_end_o   = mend_q;
    assign width_o      = width_q;
    assign timeout_o    = tmo_q;

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: validates leader, 32 data bits and stop burst; reports commands and repeats.
module nec_ir_decoder
    import nec_ir_decoder_pkg::*;
#(
    parameter int CLKS_PER_TICK = 500,
    parameter bit IR_ACTIVE_LOW = 1'b1,
    parameter bit CHECK_ADDR    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    nec_ir_decoder_if.master  bus
);

    logic        mark_start, mark_end, space_end, timeout;
    logic [11:0] width;

    ir_pulse_timer #(
        .CLKS_PER_TICK (CLKS_PER_TICK),
        .IR_ACTIVE_LOW (IR_ACTIVE_LOW)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_i         (bus.ir_in),
        .mark_start_o (mark_start),
        .mark_end_o   (mark_end),
        .space_end_o  (space_end),
        .width_o      (width),
        .timeout_o    (timeout)
    );

    nec_state_e  state_q, state_d;
    logic [31:0] sr_q, sr_d;
    logic [5:0]  bcnt_q, bcnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  addr_q, addr_d;
    logic        have_q, have_d;
    logic        valid_q, valid_d;
    logic        rpt_q, rpt_d;
    logic        err_q, err_d;

    nec_frame_t  frame;
    logic        frame_ok;
    logic        bit_mark_ok;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bcnt_d   = bcnt_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        have_d   = have_q;
        valid_d  = 1'b0;
        rpt_d    = 1'b0;
        err_d    = 1'b0;

        frame       = nec_frame_t'(sr_q);
        frame_ok    = (frame.cmd_n == ~frame.cmd) &&
                      ((CHECK_ADDR == 1'b0) || (frame.addr_n == ~frame.addr));
        bit_mark_ok = in_win(width, BIT_MARK_MIN, BIT_MARK_MAX);

        if (timeout && (state_q != S_IDLE)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mark_start) state_d = S_LEAD_MARK;
                end
                S_LEAD_MARK: begin
                    if (mark_end) begin
                        if (in_win(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                            state_d = S_LEAD_SPACE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_LEAD_SPACE: begin
                    if (space_end) begin
                        if (in_win(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                            bcnt_d  = '0;
                            state_d = S_BIT_MARK;
                        end else if (in_win(width, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                            state_d = S_RPT_MARK;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_BIT_MARK: begin
                    if (mark_end) begin
                        if (bit_mark_ok) begin
                            state_d = S_BIT_SPACE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_BIT_SPACE: begin
                    if (space_end) begin
                        if (in_win(width, ZERO_SPACE_MIN, ZERO_SPACE_MAX) ||
                            in_win(width, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                            sr_d    = {in_win(width, ONE_SPACE_MIN, ONE_SPACE_MAX), sr_q[31:1]};
                            bcnt_d  = bcnt_q + 6'd1;
                            state_d = (bcnt_q == 6'(NEC_BITS - 1)) ? S_STOP_MARK : S_BIT_MARK;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_STOP_MARK: begin
                    if (mark_end) begin
                        if (bit_mark_ok && frame_ok) begin
                            cmd_d   = frame.cmd;
                            addr_d  = frame.addr;
                            valid_d = 1'b1;
                            have_d  = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                        end
                        state_d = S_IDLE;
                    end
                end
                S_RPT_MARK: begin
                    if (mark_end) begin
                        // A repeat with nothing to repeat is silently dropped.
                        if (bit_mark_ok) rpt_d = have_q;
                        else             err_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            bcnt_q  <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            have_q  <= 1'b0;
            valid_q <= 1'b0;
            rpt_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            have_q  <= have_d;
            valid_q <= valid_d;
            rpt_q   <= rpt_d;
            err_q   <= err_d;
        end
    end

    assign bus.ir_cmd    = cmd_q;
    assign bus.ir_addr   = addr_q;
    assign bus.ir_valid  = valid_q;
    assign bus.ir_repeat = rpt_q;
    assign bus.ir_err    = err_q;

endmodule
